// File: rtl/spi_pnb_pkg.sv
// spi_pnb_pkg: shared SPI mode constants, FSM state type and clog2 helper
package spi_pnb_pkg;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/spi_pnb_fifo.sv
// spi_pnb_fifo: word FIFO with power-of-2 depth; level tells full from empty
module spi_pnb_fifo
  import spi_pnb_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic we, re;
  assign full = level == DEPTH[AW:0];
  assign empty = level == '0;
  assign we = wr && !full;
  assign re = rd && !empty;
  assign dout = mem[rp];
  // pointers wrap naturally; a read sees the pre-write state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
      level <= level + {{AW{1'b0}}, we} - {{AW{1'b0}}, re};
    end
  // storage array
  always_ff @(posedge clk)
    if (we) mem[wp] <= din;
endmodule

// File: rtl/spi_pnb_tx.sv
// spi_pnb_tx: SPI slave transmit path, FIFO-buffered; SPI_PNB_TX_UNDERRUN_CNT_EN adds underrun_cnt
module spi_pnb_tx
  import spi_pnb_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic [DW-1:0] IDLE_WORD = '0,
  localparam int LW = clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sck,
  input  logic          cs_n,
  input  logic [DW-1:0] dataout,
  input  logic          vld,
  output logic          rdy,
  output logic          sdo,
  output logic          busy,
  output logic          underrun,
  output logic [LW-1:0] level
`ifdef SPI_PNB_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]    underrun_cnt
`endif
);
  localparam int CW = clog2(DW + 1);
  localparam logic [1:0] MODE = {CPOL, CPHA};
  localparam bit SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
  logic [2:0] sck_p, cs_p;
  logic lead, trail, smp_e, sh_e, cs_fall, cs_rise;
  logic ld, shf, pop, full, empty, obit, first;
  logic [DW-1:0] head, word, shreg, nxt;
  logic [CW-1:0] bit_cnt;
  state_t state;
  spi_pnb_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr(vld), .din(dataout), .rd(pop),
    .dout(head), .full(full), .empty(empty), .level(level)
  );
  assign rdy = !full;
  // two-flop synchronisers plus one edge-detect stage; cs resets low so a held-low cs_n never restarts a frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_p <= {3{CPOL}};
      cs_p <= '0;
    end else begin
      sck_p <= {sck_p[1:0], sck};
      cs_p <= {cs_p[1:0], cs_n};
    end
  // edge classification, word load/shift decisions and next shift register value
  always_comb begin
    lead = sck_p[1] != CPOL && sck_p[2] == CPOL;
    trail = sck_p[1] == CPOL && sck_p[2] != CPOL;
    smp_e = SAMPLE_LEAD ? lead : trail;
    sh_e = SAMPLE_LEAD ? trail : lead;
    cs_fall = !cs_p[1] && cs_p[2];
    cs_rise = cs_p[1] && !cs_p[2];
    ld = !cs_rise && (state == LOAD || (state == SHIFT && sh_e && !first && bit_cnt == CW'(DW)));
    shf = !cs_rise && state == SHIFT && sh_e && !first && bit_cnt != CW'(DW);
    pop = ld && !empty;
    word = empty ? IDLE_WORD : head;
    nxt = ld ? word : shf ? (MSB_FIRST ? shreg << 1 : shreg >> 1) : shreg;
    obit = MSB_FIRST ? nxt[DW-1] : nxt[0];
  end
  // frame FSM with registered sdo, busy and underrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      first <= 1'b0;
      sdo <= 1'b0;
      busy <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= ld && empty;
      shreg <= nxt;
      sdo <= !cs_rise && state != IDLE && obit;
      if (cs_rise) begin
        state <= IDLE;
        busy <= 1'b0;
      end else
        case (state)
          IDLE: if (cs_fall) begin
            state <= LOAD;
            busy <= 1'b1;
          end
          LOAD: begin
            state <= SHIFT;
            bit_cnt <= '0;
            first <= CPHA;
          end
          default: begin
            bit_cnt <= ld ? '0 : smp_e ? bit_cnt + 1'b1 : bit_cnt;
            if (sh_e) first <= 1'b0;
          end
        endcase
    end
`ifdef SPI_PNB_TX_UNDERRUN_CNT_EN
  // saturating underrun counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_spi_pnb_tx.sv
// tb_spi_pnb_tx: randomized self-checking bench for a mode-0 MSB-first and a mode-3 LSB-first instance
module tb_spi_pnb_tx;
  localparam logic [1:0] POL = 2'b10;
  localparam logic [1:0] PHA = 2'b10;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] sck, cs_n, vld;
  logic [7:0] din [2];
  logic rdy [2], sdo [2], busy [2], underrun [2];
  logic [2:0] level [2];
  logic [7:0] ucnt [2];
  logic [7:0] q0[$], q1[$];
  bit eq0[$], eq1[$];
  int um [2], uh [2], hc [2];
  int errors = 0, checks = 0, cur = 0;
  logic [31:0] cap = '0;
  logic eb;
  event smp;

  always #5 clk = ~clk;

  spi_pnb_tx u0 (
    .clk(clk), .rst_n(rst_n), .sck(sck[0]), .cs_n(cs_n[0]), .dataout(din[0]), .vld(vld[0]),
    .rdy(rdy[0]), .sdo(sdo[0]), .busy(busy[0]), .underrun(underrun[0]), .level(level[0])
`ifdef SPI_PNB_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt[0])
`endif
  );

  spi_pnb_tx #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .IDLE_WORD(8'hC3)) u1 (
    .clk(clk), .rst_n(rst_n), .sck(sck[1]), .cs_n(cs_n[1]), .dataout(din[1]), .vld(vld[1]),
    .rdy(rdy[1]), .sdo(sdo[1]), .busy(busy[1]), .underrun(underrun[1]), .level(level[1])
`ifdef SPI_PNB_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt[1])
`endif
  );

  function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, cur, a, e);
    end
  endfunction

  function automatic int cnt(input int d);
    return d == 0 ? q0.size() : q1.size();
  endfunction

  function automatic void mpush(input int d, input logic [7:0] w);
    if (d == 0) q0.push_back(w);
    else q1.push_back(w);
  endfunction

  function automatic logic [7:0] mpop(input int d);
    logic [7:0] r;
    if (cnt(d) > 0) begin
      if (d == 0) r = q0.pop_front();
      else r = q1.pop_front();
    end else begin
      r = d == 0 ? 8'h00 : 8'hC3;
      um[d]++;
      if (hc[d] < 255) hc[d]++;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (underrun[0] === 1'b1) uh[0]++;
    if (underrun[1] === 1'b1) uh[1]++;
  end

  always @(smp) begin
    if ((cur == 0 ? eq0.size() : eq1.size()) == 0) chk("sdo_extra", 32'd1, 32'd0);
    else begin
      if (cur == 0) eb = eq0.pop_front();
      else eb = eq1.pop_front();
      chk("sdo", sdo[cur], eb);
    end
    cap = {cap[30:0], sdo[cur]};
  end

  task automatic st(input int d);
    cur = d;
    chk("level", level[d], cnt(d));
    chk("rdy", rdy[d], cnt(d) < 4);
  endtask

  task automatic wr(input int d, input logic [7:0] w);
    @(negedge clk);
    st(d);
    din[d] = w;
    vld[d] = 1'b1;
    @(negedge clk);
    vld[d] = 1'b0;
    if (cnt(d) < 4) mpush(d, w);
  endtask

  task automatic frame(input int d, input int n, input int md, input logic [7:0] w);
    logic [7:0] wd;
    int k, lvx, m;
    k = 1 + (n - 1) / 8;
    lvx = (cnt(d) > 0 ? cnt(d) - 1 : 0) + (md != 0 ? 1 : 0);
    m = 0;
    for (int j = 0; j < k; j++) begin
      wd = mpop(d);
      if (j == 0 && md != 0) mpush(d, w);
      for (int i = 0; i < 8; i++) begin
        if (m < n) begin
          if (d == 0) eq0.push_back(wd[7 - i]);
          else eq1.push_back(wd[i]);
        end
        m++;
      end
    end
    @(negedge clk);
    cur = d;
    cs_n[d] = 1'b0;
    if (md == 2) begin
      repeat (3) @(negedge clk);
      din[d] = w;
      vld[d] = 1'b1;
      @(negedge clk);
      vld[d] = 1'b0;
      repeat (4) @(negedge clk);
    end else repeat (8) @(negedge clk);
    chk("busy_on", busy[d], 1);
    chk("level_load", level[d], lvx);
    chk("rdy_load", rdy[d], lvx < 4);
    for (int i = 0; i < n; i++) begin
      sck[d] = ~POL[d];
      if (!PHA[d]) -> smp;
      repeat (4) @(negedge clk);
      sck[d] = POL[d];
      if (PHA[d]) -> smp;
      if (i == n - 1 && !PHA[d]) cs_n[d] = 1'b1;
      repeat (4) @(negedge clk);
    end
    if (PHA[d]) begin
      cs_n[d] = 1'b1;
      repeat (4) @(negedge clk);
    end
    chk("busy_off", busy[d], 0);
    chk("sdo_off", sdo[d], 0);
    chk("bits_left", d == 0 ? eq0.size() : eq1.size(), 0);
    chk("level_end", level[d], cnt(d));
    chk("underruns", uh[d], um[d]);
`ifdef SPI_PNB_TX_UNDERRUN_CNT_EN
    chk("underrun_cnt", ucnt[d], hc[d]);
`endif
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int u, d, nw;
    rst_n = 1'b0;
    sck = POL;
    cs_n = 2'b11;
    vld = 2'b00;
    din[0] = '0;
    din[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cur = i;
      chk("rst_level", level[i], 0);
      chk("rst_rdy", rdy[i], 1);
      chk("rst_sdo", sdo[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_underrun", underrun[i], 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wr(0, 8'hA5);
    frame(0, 8, 0, 8'h00);
    chk("a5_bits", cap[7:0], 8'hA5);
    wr(0, 8'h3C); wr(0, 8'hF0); wr(0, 8'h81); wr(0, 8'h7E);
    @(negedge clk);
    chk("burst_rdy_full", rdy[0], 0);
    chk("burst_level_full", level[0], 4);
    frame(0, 32, 0, 8'h00);
    chk("burst_bits", cap, 32'h3CF0817E);
    u = uh[0];
    frame(0, 16, 0, 8'h00);
    chk("idle_bits", cap[15:0], 16'h0000);
    chk("underrun_pulses", uh[0] - u, 2);
    wr(1, 8'h01);
    frame(1, 8, 0, 8'h00);
    chk("mode3_bits", cap[7:0], 8'h80);
    frame(1, 8, 0, 8'h00);
    chk("mode3_idle_bits", cap[7:0], 8'hC3);
    wr(0, 8'hFF);
    frame(0, 3, 0, 8'h00);
    chk("abort_bits", cap[2:0], 3'b111);
    wr(0, 8'h00);
    frame(0, 8, 0, 8'h00);
    chk("after_abort_bits", cap[7:0], 8'h00);
    wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33); wr(0, 8'h44); wr(0, 8'h55);
    @(negedge clk);
    din[0] = 8'h66;
    vld[0] = 1'b1;
    frame(0, 8, 1, 8'h66);
    chk("hold_bits", cap[7:0], 8'h11);
    vld[0] = 1'b0;
    @(negedge clk);
    chk("hold_level", level[0], 4);
    frame(0, 32, 0, 8'h00);
    chk("hold_burst_bits", cap, 32'h22334466);
    frame(0, 8, 2, 8'h99);
    chk("wr_pop_empty_bits", cap[7:0], 8'h00);
    frame(0, 8, 0, 8'h00);
    chk("wr_pop_queued_bits", cap[7:0], 8'h99);
    for (int it = 0; it < 24; it++) begin
      d = $urandom_range(0, 1);
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) wr(d, 8'($urandom));
      frame(d, $urandom_range(1, 40), 0, 8'h00);
    end
    wr(0, 8'h12); wr(0, 8'h34);
    @(negedge clk);
    cs_n[0] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sck[0] = 1'b1; repeat (4) @(negedge clk);
      sck[0] = 1'b0; repeat (4) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    cur = 0;
    chk("midrst_level", level[0], 0);
    chk("midrst_sdo", sdo[0], 0);
    chk("midrst_rdy", rdy[0], 1);
    chk("midrst_busy", busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    hc[0] = 0;
    hc[1] = 0;
    for (int i = 0; i < 3; i++) begin
      sck[0] = 1'b1; repeat (4) @(negedge clk);
      sck[0] = 1'b0; repeat (4) @(negedge clk);
    end
    chk("noresume_busy", busy[0], 0);
    chk("noresume_sdo", sdo[0], 0);
    cs_n[0] = 1'b1;
    repeat (4) @(negedge clk);
    wr(0, 8'h5A);
    frame(0, 8, 0, 8'h00);
    chk("post_rst_bits", cap[7:0], 8'h5A);
`ifdef SPI_PNB_TX_UNDERRUN_CNT_EN
    frame(0, 8 * 260, 0, 8'h00);
    chk("underrun_cnt_sat", ucnt[0], 8'hFF);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
